// File: rtl/dag_addr_seq.sv
// DAG post-modify address sequencer: I/M/L/B banks, 2-stage pipe,
// circular-buffer correction and stage-2 to stage-1 index forwarding.
module dag_addr_seq #(
  parameter int AW   = 14,
  parameter int NREG = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [1:0]    wr_bank,
  input  logic [1:0]    wr_idx,
  input  logic [AW-1:0] wr_data,
  input  logic [1:0]    rd_bank,
  input  logic [1:0]    rd_idx,
  output logic [AW-1:0] rd_data,
  input  logic          req_valid,
  input  logic [1:0]    req_i,
  input  logic [1:0]    req_m,
  output logic          req_ready,
  output logic          addr_valid,
  output logic [AW-1:0] addr,
  output logic          addr_wrap
);

  localparam int XW = AW + 2;

  logic [AW-1:0] ireg [NREG];
  logic [AW-1:0] mreg [NREG];
  logic [AW-1:0] lreg [NREG];
  logic [AW-1:0] breg [NREG];

  logic          s2_valid;
  logic [1:0]    s2_idx;
  logic [AW-1:0] s2_next;

  logic          accept;
  logic          wb_en;
  logic          fwd;
  logic [AW-1:0] icur;
  logic [AW-1:0] mval;
  logic [AW-1:0] lval;
  logic [AW-1:0] bval;
  logic signed [XW-1:0] raw;
  logic signed [XW-1:0] lim;
  logic signed [XW-1:0] bx;
  logic [AW-1:0] nxt;
  logic          wrap;
  logic [AW-1:0] rd_sel;

  assign req_ready  = ~wr_en;
  assign accept     = req_valid & ~wr_en;
  assign addr_valid = s2_valid;

  // A host write to the same I register overrides the writeback.
  assign wb_en = s2_valid &
                 ~(wr_en && wr_bank == 2'd0 && wr_idx == s2_idx);
  assign fwd   = wb_en && (s2_idx == req_i);

  assign icur = fwd ? s2_next : ireg[req_i];
  assign mval = mreg[req_m];
  assign lval = lreg[req_i];
  assign bval = breg[req_i];

  assign raw = signed'({2'b00, icur})
             + signed'({{(XW-AW){mval[AW-1]}}, mval});
  assign bx  = signed'({2'b00, bval});
  assign lim = signed'({2'b00, bval} + {2'b00, lval});

  always_comb begin
    nxt  = raw[AW-1:0];
    wrap = 1'b0;
    if (lval != '0) begin
      if (!mval[AW-1] && raw >= lim) begin
        nxt  = raw[AW-1:0] - lval;
        wrap = 1'b1;
      end else if (mval[AW-1] && raw < bx) begin
        nxt  = raw[AW-1:0] + lval;
        wrap = 1'b1;
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    unique case (rd_bank)
      2'd0: rd_sel = ireg[rd_idx];
      2'd1: rd_sel = mreg[rd_idx];
      2'd2: rd_sel = lreg[rd_idx];
      2'd3: rd_sel = breg[rd_idx];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NREG; k++) begin
        ireg[k] <= '0;
        mreg[k] <= '0;
        lreg[k] <= '0;
        breg[k] <= '0;
      end
      s2_valid  <= 1'b0;
      s2_idx    <= '0;
      s2_next   <= '0;
      addr      <= '0;
      addr_wrap <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (wb_en)
        ireg[s2_idx] <= s2_next;
      if (wr_en) begin
        unique case (wr_bank)
          2'd0: ireg[wr_idx] <= wr_data;
          2'd1: mreg[wr_idx] <= wr_data;
          2'd2: lreg[wr_idx] <= wr_data;
          2'd3: breg[wr_idx] <= wr_data;
        endcase
      end
      s2_valid <= accept;
      if (accept) begin
        s2_idx    <= req_i;
        s2_next   <= nxt;
        addr      <= icur;
        addr_wrap <= wrap;
      end
      rd_data <= rd_sel;
    end
  end

endmodule

// File: tb/tb_dag_addr_seq.sv
// Random + directed bench for dag_addr_seq; sequential reference model
// feeds a scoreboard queue drained by an independent output monitor.
module tb_dag_addr_seq;
  localparam int AW  = 14;
  localparam int MOD = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_bank = '0;
  logic [1:0]    wr_idx = '0;
  logic [AW-1:0] wr_data = '0;
  logic [1:0]    rd_bank = '0;
  logic [1:0]    rd_idx = '0;
  logic [AW-1:0] rd_data;
  logic          req_valid = 1'b0;
  logic [1:0]    req_i = '0;
  logic [1:0]    req_m = '0;
  logic          req_ready;
  logic          addr_valid;
  logic [AW-1:0] addr;
  logic          addr_wrap;

  dag_addr_seq #(.AW(AW), .NREG(4)) dut (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_bank(rd_bank), .rd_idx(rd_idx),
    .rd_data(rd_data),
    .req_valid(req_valid), .req_i(req_i),
    .req_m(req_m), .req_ready(req_ready),
    .addr_valid(addr_valid), .addr(addr),
    .addr_wrap(addr_wrap)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int a;
    int w;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;
  int bank[4][4];

  function automatic void chk(string n, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  n, act, exp);
  endfunction

  function automatic int sx(int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Sequential semantics: each accepted op sees all earlier ops.
  function automatic void model_req(int i, int m);
    int icur, mv, raw, l, b, nx, w;
    exp_t e;
    icur = bank[0][i];
    mv   = sx(bank[1][m]);
    l    = bank[2][i];
    b    = bank[3][i];
    raw  = icur + mv;
    nx   = raw;
    w    = 0;
    if (l != 0 && mv >= 0 && raw >= b + l) begin
      nx = raw - l;
      w  = 1;
    end else if (l != 0 && mv < 0 && raw < b) begin
      nx = raw + l;
      w  = 1;
    end
    bank[0][i] = ((nx % MOD) + MOD) % MOD;
    e.a = icur;
    e.w = w;
    sbq.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        bank[b][k] = 0;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (addr_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL spurious_addr: addr 0x%0h, none expected",
                 addr);
      end else begin
        e = sbq.pop_front();
        chk("addr", int'(addr), e.a);
        chk("addr_wrap", int'(addr_wrap), e.w);
      end
    end
  end

  task automatic cyc(bit we, int wb, int wi, int wd,
                     bit rv, int ri, int rm);
    wr_en     = we;
    wr_bank   = wb[1:0];
    wr_idx    = wi[1:0];
    wr_data   = wd[AW-1:0];
    req_valid = rv;
    req_i     = ri[1:0];
    req_m     = rm[1:0];
    if (we) bank[wb][wi] = wd;
    else if (rv) model_req(ri, rm);
    #1;
    chk("req_ready", int'(req_ready), int'(!we));
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(int b, int i, int d);
    cyc(1'b1, b, i, d, 1'b0, 0, 0);
  endtask

  task automatic rq(int i, int m);
    cyc(1'b0, 0, 0, 0, 1'b1, i, m);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++)
      cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic rd(string n, int b, int i, int exp);
    wr_en     = 1'b0;
    req_valid = 1'b0;
    rd_bank   = b[1:0];
    rd_idx    = i[1:0];
    @(posedge CLK);
    #1;
    chk(n, int'(rd_data), exp);
  endtask

  task automatic rd_all(string n);
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        rd(n, b, k, bank[b][k]);
  endtask

  function automatic int rnd_data(int b);
    int s;
    case (b)
      0: begin
        s = $urandom_range(0, 2);
        if (s == 0) return 'h100 + $urandom_range(0, 31);
        if (s == 1) return 'h3FF0 + $urandom_range(0, 15);
        return $urandom_range(0, MOD - 1);
      end
      1: begin
        s = $urandom_range(0, 16) - 8;
        return (s < 0) ? s + MOD : s;
      end
      2: return ($urandom_range(0, 2) == 0) ?
                0 : $urandom_range(1, 24);
      default: return ($urandom_range(0, 1) == 0) ?
                'h100 : $urandom_range(0, MOD - 1);
    endcase
  endfunction

  initial begin
    int r, b;
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_addr_valid", int'(addr_valid), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_addr_wrap", int'(addr_wrap), 0);
    rd("rst_I0", 0, 0, 0);
    rd("rst_M3", 1, 3, 0);
    rd("rst_L2", 2, 2, 0);
    rd("rst_B1", 3, 1, 0);

    wr(0, 0, 'h10); wr(1, 0, 3); wr(2, 0, 0);
    rq(0, 0); rq(0, 0); rq(0, 0);
    idle(2);
    rd("lin_I0", 0, 0, 'h19);

    wr(3, 1, 'h100); wr(2, 1, 8);
    wr(0, 1, 'h106); wr(1, 1, 3);
    rq(1, 1); rq(1, 1); rq(1, 1);
    idle(2);
    rd("circ_fwd_I1", 0, 1, 'h107);

    wr(0, 1, 'h101); wr(1, 2, 'h3FFD);
    rq(1, 2); rq(1, 2);
    idle(2);
    rd("circ_bwd_I1", 0, 1, 'h103);

    wr(0, 3, 'h3FFE); wr(1, 3, 4); wr(2, 3, 0);
    rq(3, 3);
    idle(2);
    rd("lin_wrap_I3", 0, 3, 'h0002);

    wr(0, 2, 'h20); wr(1, 1, 1); wr(2, 2, 0);
    rq(2, 1);
    cyc(1'b1, 0, 2, 'h55, 1'b1, 2, 1);
    idle(2);
    rd("collide_I2", 0, 2, 'h55);

    rq(0, 0);
    wr_en     = 1'b0;
    req_valid = 1'b0;
    RST       = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_clear();
    chk("midrst_addr_valid", int'(addr_valid), 0);
    chk("midrst_queue", sbq.size(), 0);
    rd_all("midrst_reg");

    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      b = $urandom_range(0, 3);
      if (r <= 2)
        wr(b, $urandom_range(0, 3), rnd_data(b));
      else if (r <= 7)
        rq($urandom_range(0, 3), $urandom_range(0, 3));
      else if (r == 8)
        cyc(1'b1, b, $urandom_range(0, 3), rnd_data(b),
            1'b1, $urandom_range(0, 3), $urandom_range(0, 3));
      else
        idle(1);
    end
    idle(3);
    rd_all("rand_reg");
    chk("queue_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
